// File: rtl/qsys_onchip_memory_dp_if.sv
// Avalon-MM slave port bundle for the dual-port on-chip RAM; one instance per port.
interface qsys_onchip_memory_dp_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 14
);
  logic [ADDR_WIDTH-1:0]   address;
  logic                    chipselect;
  logic                    read;
  logic                    write;
  logic [DATA_WIDTH/8-1:0] byteenable;
  logic [DATA_WIDTH-1:0]   writedata;
  logic [DATA_WIDTH-1:0]   readdata;
  logic                    readdatavalid;
  logic                    waitrequest;

  modport master (
    output address, chipselect, read, write, byteenable, writedata,
    input  readdata, readdatavalid, waitrequest
  );

  modport slave (
    input  address, chipselect, read, write, byteenable, writedata,
    output readdata, readdatavalid, waitrequest
  );
endinterface

// File: rtl/qsys_onchip_memory_dp.sv
// True dual-port byte-enabled RAM with two Avalon-MM slaves, pipelined reads
// (latency 1 or 2) and an optional post-reset zero-fill sequencer.
module qsys_onchip_memory_dp #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 14,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          reset_req,
  input  logic                          clken,
  qsys_onchip_memory_dp_if.slave        s1,
  qsys_onchip_memory_dp_if.slave        s2,
  output logic                          busy
);
  localparam int NB    = DATA_WIDTH / 8;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {ST_RESET, ST_CLEAR, ST_READY} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   clr_addr_q, clr_addr_d;
  logic                    en, ready, clr_we, clr_last, wait_req;
  logic                    acc1, acc2, we1, we2, rd1, rd2;
  logic [ADDR_WIDTH-1:0]   addr1, addr2;
  logic [DATA_WIDTH-1:0]   wdata1, wdata2, ram_rd1, ram_rd2;
  logic [NB-1:0]           be1, be2;
  logic [READ_LATENCY-1:0] vld1_q, vld1_d, vld2_q, vld2_d;

  assign en       = clken & ~reset_req;
  assign clr_last = (clr_addr_q == {ADDR_WIDTH{1'b1}});

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_RESET;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET: state_d = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      ST_CLEAR: if (en && clr_last) state_d = ST_READY;
      ST_READY: state_d = ST_READY;
      default:  state_d = ST_RESET;
    endcase
  end

  always_comb begin
    ready  = 1'b0;
    clr_we = 1'b0;
    busy   = 1'b0;
    case (state_q)
      ST_RESET: busy = (CLEAR_ON_RESET != 0);
      ST_CLEAR: begin
        busy   = 1'b1;
        clr_we = en;
      end
      ST_READY: ready = 1'b1;
      default:  ;
    endcase
  end

  // Clear address saturates at the top; it is re-armed to 0 outside CLEAR.
  always_comb begin
    clr_addr_d = clr_addr_q;
    if (state_q != ST_CLEAR)   clr_addr_d = '0;
    else if (en && !clr_last)  clr_addr_d = clr_addr_q + ADDR_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) clr_addr_q <= '0;
    else       clr_addr_q <= clr_addr_d;
  end

  assign wait_req       = ~ready | ~en;
  assign s1.waitrequest = wait_req;
  assign s2.waitrequest = wait_req;

  assign acc1 = s1.chipselect & (s1.read | s1.write) & ~wait_req;
  assign acc2 = s2.chipselect & (s2.read | s2.write) & ~wait_req;
  // A combined read+write is treated as a plain write.
  assign rd1  = acc1 & s1.read & ~s1.write;
  assign rd2  = acc2 & s2.read & ~s2.write;
  assign we1  = (acc1 & s1.write) | clr_we;
  assign we2  = acc2 & s2.write;

  // Port 1 doubles as the zero-fill path while the clear sequencer runs.
  assign addr1  = clr_we ? clr_addr_q : s1.address;
  assign wdata1 = clr_we ? '0 : s1.writedata;
  assign be1    = clr_we ? '1 : s1.byteenable;
  assign addr2  = s2.address;
  assign wdata2 = s2.writedata;
  assign be2    = s2.byteenable;

  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_lane
      logic [7:0] mem [DEPTH];
      logic [7:0] rd1_q, rd2_q;

      // Port 1 is written last so it owns lanes both ports enable.
      always_ff @(posedge clk) begin
        if (we2 && be2[gi]) mem[addr2] <= wdata2[gi*8 +: 8];
        if (we1 && be1[gi]) mem[addr1] <= wdata1[gi*8 +: 8];
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          rd1_q <= '0;
          rd2_q <= '0;
        end else begin
          if (rd1) rd1_q <= mem[addr1];
          if (rd2) rd2_q <= mem[addr2];
        end
      end

      assign ram_rd1[gi*8 +: 8] = rd1_q;
      assign ram_rd2[gi*8 +: 8] = rd2_q;
    end
  endgenerate

  always_comb begin
    vld1_d = vld1_q;
    vld2_d = vld2_q;
    if (en) begin
      vld1_d = (vld1_q << 1) | READ_LATENCY'(rd1);
      vld2_d = (vld2_q << 1) | READ_LATENCY'(rd2);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld1_q <= '0;
      vld2_q <= '0;
    end else begin
      vld1_q <= vld1_d;
      vld2_q <= vld2_d;
    end
  end

  assign s1.readdatavalid = vld1_q[READ_LATENCY-1] & en;
  assign s2.readdatavalid = vld2_q[READ_LATENCY-1] & en;

  generate
    if (READ_LATENCY >= 2) begin : g_lat2
      logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d, rdata2_q, rdata2_d;

      always_comb begin
        rdata1_d = rdata1_q;
        rdata2_d = rdata2_q;
        if (en && vld1_q[0]) rdata1_d = ram_rd1;
        if (en && vld2_q[0]) rdata2_d = ram_rd2;
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          rdata1_q <= '0;
          rdata2_q <= '0;
        end else begin
          rdata1_q <= rdata1_d;
          rdata2_q <= rdata2_d;
        end
      end

      assign s1.readdata = rdata1_q;
      assign s2.readdata = rdata2_q;
    end else begin : g_lat1
      assign s1.readdata = ram_rd1;
      assign s2.readdata = ram_rd2;
    end
  endgenerate
endmodule

// File: doc/qsys_onchip_memory_dp.md
# qsys_onchip_memory_dp

Parametrised true-dual-port on-chip RAM with two Avalon-MM slave ports, s1 and s2, for the Qsys system. It generalises the single-port onchip memory in four ways: configurable data width and depth, a selectable 1- or 2-cycle pipelined read with readdatavalid, defined cross-port collision behaviour, and an optional zero-fill state machine that runs after reset. Nios II masters or DMA masters connect to either port.

## Interface
- DATA_WIDTH, 32, word width; must be a multiple of 8.
- ADDR_WIDTH, 14, word address width; DEPTH = 2^ADDR_WIDTH.
- READ_LATENCY, 1, cycles from read acceptance to readdatavalid; legal values are 1 and 2.
- CLEAR_ON_RESET, 1, when 1, zero-fill all words after reset.

Ports (x = 1 or 2; each s1 port has an identical s2 port):
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high reset.
- reset_req  in  1  request to freeze memory activity; acts like clken low.
- clken  in  1  global clock enable.
- sx_address  in  ADDR_WIDTH  word address.
- sx_chipselect  in  1  port select.
- sx_read  in  1  read request.
- sx_write  in  1  write request.
- sx_byteenable  in  DATA_WIDTH/8  byte lanes to write.
- sx_writedata  in  DATA_WIDTH  write data.
- sx_readdata  out  DATA_WIDTH  read data.
- sx_readdatavalid  out  1  one-cycle pulse marking valid readdata.
- sx_waitrequest  out  1  command not accepted this cycle.
- busy  out  1  high while the clear FSM runs.

## Operation
- Enable: en = clken & ~reset_req.
- FSM states are RESET, CLEAR and READY.
  - reset high forces RESET from any state.
  - RESET -> CLEAR if CLEAR_ON_RESET = 1; otherwise RESET -> READY.
  - CLEAR writes all-zero to clr_addr through the s1 port when en = 1. It increments clr_addr with no wrap.
  - CLEAR -> READY after address DEPTH-1 is written.
  - When en = 0, CLEAR holds both state and clr_addr.
- sx_waitrequest = 1 whenever state != READY or en = 0. No command is accepted while waitrequest is high.
- Acceptance: chipselect & (read | write) & ~waitrequest.
- If read and write are both asserted, the write executes and no readdatavalid is produced.
- Writes affect only the bytes enabled by byteenable.
- Cross-port collision, same address in the same cycle:
  - Both ports write: for each byte lane enabled on both ports, s1 data wins. Lanes enabled on only one port take that port's data.
  - One port writes, the other reads: the read returns the old data (read-first).
- Same-port read returns the stored contents. A write on the previous cycle is visible.
- Read pipeline:
  - A shift register of depth READ_LATENCY carries a valid bit per port.
  - With READ_LATENCY = 2, readdata is registered once more after the RAM output.
  - The pipeline advances only when en = 1. When en = 0, the pipeline holds its contents and readdatavalid is forced to 0.
- Reset mid-operation: in-flight reads are discarded (no readdatavalid). A CLEAR in progress restarts from address 0.
- RAM contents are not reset except by CLEAR.

## Timing
- Reset values:
  - sx_readdata = 0, sx_readdatavalid = 0.
  - sx_waitrequest = 1, busy = CLEAR_ON_RESET.
  - clr_addr = 0.
- With CLEAR_ON_RESET = 1 and en held at 1:
  - CLEAR occupies DEPTH cycles after the first clock edge with reset low.
  - waitrequest falls and busy falls on the same edge, DEPTH+1 edges after reset deasserts.
- With CLEAR_ON_RESET = 0, waitrequest falls 1 edge after reset deasserts.
- Read accepted at edge n: readdatavalid and readdata are valid in the cycle after edge n+READ_LATENCY-1 (i.e. sampled at edge n+READ_LATENCY), assuming en stays 1. Each cycle with en = 0 adds one cycle to that.
- Throughput: one command per port per cycle. Back-to-back reads produce back-to-back readdatavalid pulses.
- readdata holds its last value when readdatavalid = 0.

## Test plan
- Reset clear, DEPTH = 16, CLEAR_ON_RESET = 1:
  - Preload via writes, then pulse reset.
  - busy stays high for 16 cycles, waitrequest falls at edge 17, and every address reads 0.
- Byte-enable write: s1 writes 0xAABBCCDD with byteenable 0b0101 over 0x11223344.
  - A subsequent read returns 0x11BB33DD.
- Latency 2: s2 reads addresses 0..3 back-to-back.
  - Four consecutive readdatavalid pulses, the first sampled 2 edges after the first accept, with data in order.
- Collision: in the same cycle, s1 writes 0x000000FF (be 0b0011) and s2 writes 0x12345678 (be 0b1110) to address 5.
  - Address 5 reads 0x123400FF.
  - Read-vs-write on the same address returns the old value.
- Stall: clken = 0 for 3 cycles immediately after a read accept.
  - waitrequest is high during the stall, no readdatavalid appears, and valid arrives 3 cycles late with the correct data.
  - reset_req = 1 gives the same behaviour.
- Reset mid-clear (reset asserted at clr_addr = 7) and mid-read (one read in flight):
  - The in-flight read produces no readdatavalid.
  - CLEAR restarts at 0 and takes the full DEPTH cycles.
